aes128_round_ctrl: RTL and testbench
====================================

Name: aes128_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer.
- Owns the 128-bit state register, round-key register, round counter and Rcon generator.
- Drives an external single-round combinational datapath (sub_bytes -> shift_rows -> mix_columns -> add_round_key) and an external one-step key expander.
- Accepts plaintext/key blocks over a valid/ready handshake and returns ciphertext over a second valid/ready handshake.

Parameters:
- NR, 10, number of rounds; legal 1..10. Values below 10 are for reduced-round bring-up only. The last round always sets dp_final.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  plaintext/key block offered
- in_ready  out  1  controller can accept a block
- pt_in  in  128  plaintext, column-major byte order, byte 0 at [127:120]
- key_in  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer takes ciphertext
- ct_out  out  128  ciphertext (equals state register)
- busy  out  1  high in ROUND or DONE
- dp_state  out  128  current state to round datapath
- dp_round_key  out  128  round key for current round (= ks_key_next)
- dp_final  out  1  high in round NR; datapath bypasses mix_columns
- dp_result  in  128  round datapath output, combinational from dp_state/dp_round_key/dp_final
- ks_key  out  128  current round-key register to key expander
- ks_rcon  out  8  Rcon for current round
- ks_key_next  in  128  key expander output, combinational
- round_cnt  out  4  current round number, 0 in IDLE

Behaviour:
- Clocking: single clock clk. rst is asynchronous, active-high.
- Reset values:
  - state_reg, key_reg, ct_out, dp_state, ks_key: 0.
  - round_cnt: 0. ks_rcon: 8'h01.
  - in_ready: 1. out_valid, busy, dp_final: 0. FSM = IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg <= pt_in ^ key_in; key_reg <= key_in; round_cnt <= 1; rcon <= 8'h01; go ROUND.
- ROUND:
  - in_ready=0, busy=1. dp_final = (round_cnt == NR).
  - Each edge: state_reg <= dp_result; key_reg <= ks_key_next; rcon <= xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 0).
  - If round_cnt == NR: go DONE and round_cnt <= 0; otherwise round_cnt <= round_cnt + 1.
  - Rcon sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1B 36.
- DONE:
  - out_valid=1. ct_out stable until the handshake.
  - On out_ready: out_valid <= 0, rcon <= 01, go IDLE.
- Latency: accept edge at cycle N; out_valid first high after edge N+NR (11 edges inclusive for NR=10).
- Throughput: one block per NR+2 cycles when out_ready is held high.
- Backpressure:
  - out_ready low holds DONE indefinitely; in_ready stays 0, so a new block cannot overwrite an unread result.
  - No accept in the same cycle as the out handshake; IDLE is entered first.
- pt_in/key_in are sampled only at the accept edge and may change afterward.
- dp_result and ks_key_next are ignored outside ROUND.
- rst asserted mid-operation: immediate return to reset values; the partial result is discarded and out_valid is never raised.
- in_valid during ROUND/DONE: ignored; the sender must hold it until in_ready.

Optional Feature:
- Macro: AES128_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high at an edge in ROUND or DONE: FSM -> IDLE, round_cnt <= 0, rcon <= 01, out_valid <= 0; state_reg and key_reg are cleared to 0.
  - abort has priority over round advance and the out handshake. abort in IDLE has no effect, and the block still accepts in_valid that cycle.
- Undefined: no abort port; the only way out of ROUND is completion or rst.

Test Plan:
- FIPS-197 C.1 with real datapath/key-expander bound: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ct_out 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 edges after the accept edge.
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ct 3925841d02dc09fbdc118597196a0b32. Monitor ks_rcon = 01,02,04,08,10,20,40,80,1B,36 and dp_final high only in round 10.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ct_out stable, in_ready=0 throughout, in_valid pulses ignored. Release out_ready -> IDLE the next cycle, second block accepted, correct ct.
- Reset mid-run: assert rst during round 5 -> all outputs at reset values asynchronously, no out_valid. Next block after release produces correct ct.
- NR=1 build: pt/key from C.1 -> out_valid one edge after the accept edge; ct equals final-round transform of (pt^key) with round-1 key.
- ABORT_EN build: abort in round 3 -> IDLE next edge, out_valid stays 0. A fresh C.1 block then yields 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes128_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes128_round_ctrl_if
// Block-level handshake bundle for the iterative AES-128 sequencer.
//   in_valid / in_ready / pt_in / key_in : plaintext + key input handshake
//   out_valid / out_ready / ct_out       : ciphertext output handshake
// Modports:
//   master : the block producer / ciphertext consumer
//   slave  : the sequencer (aes128_round_ctrl)
// ---------------------------------------------------------------------------
interface aes128_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_out;

    modport master (
        output in_valid, pt_in, key_in, out_ready,
        input  in_ready, out_valid, ct_out
    );

    modport slave (
        input  in_valid, pt_in, key_in, out_ready,
        output in_ready, out_valid, ct_out
    );
endinterface

// File: rtl/aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_round_ctrl
// Iterative AES-128 encryption sequencer. Owns the state register, the
// round-key register, the round counter and the Rcon generator; the round
// transform and the key-expansion step are external combinational blocks.
//
// Parameter:
//   NR           number of rounds (1..10; below 10 only for bring-up)
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   abort        (only with AES128_ROUND_CTRL_ABORT_EN) cancel current block
//   io           aes128_round_ctrl_if.slave: input and output handshakes;
//                ct_out mirrors the state register
//   busy         high while a block is in ROUND or DONE
//   dp_state     state register to the round datapath
//   dp_round_key round key for the current round (= ks_key_next)
//   dp_final     high in round NR, datapath skips mix_columns
//   dp_result    round datapath result
//   ks_key       round-key register to the key expander
//   ks_rcon      Rcon for the current round
//   ks_key_next  key expander result
//   round_cnt    current round number, 0 outside ROUND
//
// Optional feature: define AES128_ROUND_CTRL_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module aes128_round_ctrl #(
    parameter int NR = 10
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef AES128_ROUND_CTRL_ABORT_EN
    input  logic                      abort,
`endif
    aes128_round_ctrl_if.slave        io,
    output logic                      busy,
    output logic [127:0]              dp_state,
    output logic [127:0]              dp_round_key,
    output logic                      dp_final,
    input  logic [127:0]              dp_result,
    output logic [127:0]              ks_key,
    output logic [7:0]                ks_rcon,
    input  logic [127:0]              ks_key_next,
    output logic [3:0]                round_cnt
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    fsm_e         fsm_r, fsm_s;
    logic [127:0] state_reg_r, state_reg_s;
    logic [127:0] key_reg_r, key_reg_s;
    logic [7:0]   rcon_r, rcon_s;
    logic [3:0]   round_cnt_r, round_cnt_s;
    logic         in_ready_r, in_ready_s;
    logic         out_valid_r, out_valid_s;
    logic         busy_r, busy_s;
    logic         dp_final_r, dp_final_s;
    logic         abort_s;

    // Multiply by x in GF(2^8) with the AES polynomial; steps Rcon per round.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

`ifdef AES128_ROUND_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and next-register values; status flags follow the next state
    // so they can be registered alongside it.
    always_comb begin
        fsm_s       = fsm_r;
        state_reg_s = state_reg_r;
        key_reg_s   = key_reg_r;
        rcon_s      = rcon_r;
        round_cnt_s = round_cnt_r;
        case (fsm_r)
            IDLE: begin
                if (io.in_valid) begin
                    fsm_s       = ROUND;
                    state_reg_s = io.pt_in ^ io.key_in;
                    key_reg_s   = io.key_in;
                    round_cnt_s = 4'd1;
                    rcon_s      = 8'h01;
                end else begin
                    fsm_s = IDLE;
                end
            end
            ROUND: begin
                if (abort_s) begin
                    fsm_s       = IDLE;
                    state_reg_s = 128'd0;
                    key_reg_s   = 128'd0;
                    round_cnt_s = 4'd0;
                    rcon_s      = 8'h01;
                end else begin
                    state_reg_s = dp_result;
                    key_reg_s   = ks_key_next;
                    rcon_s      = xtime(rcon_r);
                    if (round_cnt_r == LAST_ROUND) begin
                        fsm_s       = DONE;
                        round_cnt_s = 4'd0;
                    end else begin
                        round_cnt_s = round_cnt_r + 4'd1;
                    end
                end
            end
            DONE: begin
                // abort wins over the output handshake
                if (abort_s) begin
                    fsm_s       = IDLE;
                    state_reg_s = 128'd0;
                    key_reg_s   = 128'd0;
                    round_cnt_s = 4'd0;
                    rcon_s      = 8'h01;
                end else if (io.out_ready) begin
                    fsm_s  = IDLE;
                    rcon_s = 8'h01;
                end else begin
                    fsm_s = DONE;
                end
            end
            default: begin
                fsm_s       = IDLE;
                state_reg_s = 128'd0;
                key_reg_s   = 128'd0;
                round_cnt_s = 4'd0;
                rcon_s      = 8'h01;
            end
        endcase
        in_ready_s  = (fsm_s == IDLE);
        out_valid_s = (fsm_s == DONE);
        busy_s      = (fsm_s != IDLE);
        dp_final_s  = (fsm_s == ROUND) && (round_cnt_s == LAST_ROUND);
    end

    // FSM, data registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= IDLE;
            state_reg_r <= 128'd0;
            key_reg_r   <= 128'd0;
            rcon_r      <= 8'h01;
            round_cnt_r <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            dp_final_r  <= 1'b0;
        end else begin
            fsm_r       <= fsm_s;
            state_reg_r <= state_reg_s;
            key_reg_r   <= key_reg_s;
            rcon_r      <= rcon_s;
            round_cnt_r <= round_cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            dp_final_r  <= dp_final_s;
        end
    end

    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.ct_out    = state_reg_r;
    assign busy         = busy_r;
    assign dp_state     = state_reg_r;
    assign dp_round_key = ks_key_next;
    assign dp_final     = dp_final_r;
    assign ks_key       = key_reg_r;
    assign ks_rcon      = rcon_r;
    assign round_cnt    = round_cnt_r;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes128_round_ctrl
// Self-checking bench for aes128_round_ctrl. A behavioural AES round and
// key-expansion step are bound to the datapath ports; expected ciphertexts
// come from FIPS-197 constants and from a full-key-schedule reference model.
// Two instances: NR=10 (main) and NR=1 (reduced-round bring-up).
// With AES128_ROUND_CTRL_ABORT_EN defined the abort path is exercised too.
// ---------------------------------------------------------------------------
module tb_aes128_round_ctrl;

    localparam int NR = 10;
    localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    aes128_round_ctrl_if io();
    logic         busy, dp_final;
    logic [127:0] dp_state, dp_round_key, dp_result, ks_key, ks_key_next;
    logic [7:0]   ks_rcon;
    logic [3:0]   round_cnt;

    aes128_round_ctrl_if io1();
    logic         busy1, dp_final1;
    logic [127:0] dp_state1, dp_round_key1, dp_result1, ks_key1, ks_key_next1;
    logic [7:0]   ks_rcon1;
    logic [3:0]   round_cnt1;

`ifdef AES128_ROUND_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif

    aes128_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst),
`ifdef AES128_ROUND_CTRL_ABORT_EN
        .abort(abort),
`endif
        .io(io), .busy(busy), .dp_state(dp_state), .dp_round_key(dp_round_key),
        .dp_final(dp_final), .dp_result(dp_result), .ks_key(ks_key),
        .ks_rcon(ks_rcon), .ks_key_next(ks_key_next), .round_cnt(round_cnt)
    );

    aes128_round_ctrl #(.NR(1)) dut1 (
        .clk(clk), .rst(rst),
`ifdef AES128_ROUND_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .io(io1), .busy(busy1), .dp_state(dp_state1), .dp_round_key(dp_round_key1),
        .dp_final(dp_final1), .dp_result(dp_result1), .ks_key(ks_key1),
        .ks_rcon(ks_rcon1), .ks_key_next(ks_key_next1), .round_cnt(round_cnt1)
    );

    // ---------------- AES primitives ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from the definition: x^254 (GF inverse, 0 -> 0) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01; p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   b0, b1, b2, b3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = a[r + 4*((c+r)%4)];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
            if (fin)
                o[127-32*c -: 32] = {b0, b1, b2, b3};
            else
                o[127-32*c -: 32] = {gmul(b0,8'h02) ^ gmul(b1,8'h03) ^ b2 ^ b3,
                                     b0 ^ gmul(b1,8'h02) ^ gmul(b2,8'h03) ^ b3,
                                     b0 ^ b1 ^ gmul(b2,8'h02) ^ gmul(b3,8'h03),
                                     gmul(b0,8'h03) ^ b1 ^ b2 ^ gmul(b3,8'h02)};
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Behavioural datapath and key expander bound to each instance
    always_comb dp_result    = aes_round(dp_state, dp_round_key, dp_final);
    // Key expander for the NR=10 instance
    always_comb ks_key_next  = key_step(ks_key, ks_rcon);
    // Round datapath for the NR=1 instance
    always_comb dp_result1   = aes_round(dp_state1, dp_round_key1, dp_final1);
    // Key expander for the NR=1 instance
    always_comb ks_key_next1 = key_step(ks_key1, ks_rcon1);

    // ---------------- reference model ----------------
    // Full FIPS-197 word-wise key schedule, returns round key r
    function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])}
                    ^ {RCON_TAB[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                                 input int nr);
        logic [127:0] s;
        s = pt ^ key;
        for (int r = 1; r <= nr; r++) s = aes_round(s, ref_round_key(key, r), r == nr);
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] st(input logic ir, input logic ov, input logic b,
                                       input logic f, input logic [3:0] rc, input logic [7:0] rcon);
        return {ir, ov, b, f, rc, rcon};
    endfunction

    function automatic logic [15:0] dut_status();
        return {io.in_ready, io.out_valid, busy, dp_final, round_cnt, ks_rcon};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
        chk("in_ready_pre_accept", 128'(io.in_ready), 128'(1'b1));
        io.in_valid = 1'b1; io.pt_in = pt; io.key_in = key;
        @(negedge clk);
        io.in_valid = 1'b0; io.pt_in = rand128(); io.key_in = rand128();
    endtask

    // Rounds 1..NR, DONE with 'hold' cycles of backpressure, then handshake
    task automatic run_rounds(input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] want_ct, input int hold);
        logic [127:0] s_exp;
        s_exp = pt ^ key;
        for (int r = 1; r <= NR; r++) begin
            chk("round_status", 128'(dut_status()),
                128'(st(1'b0, 1'b0, 1'b1, r == NR, 4'(r), RCON_TAB[r-1])));
            chk("dp_state", dp_state, s_exp);
            chk("dp_round_key", dp_round_key, ref_round_key(key, r));
            s_exp = aes_round(s_exp, ref_round_key(key, r), r == NR);
            io.in_valid = 1'($urandom_range(0, 1));
            io.pt_in    = rand128();
            @(negedge clk);
        end
        chk("done_status", 128'(dut_status()), 128'(st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h6C)));
        chk("ct_out", io.ct_out, want_ct);
        for (int i = 0; i < hold; i++) begin
            io.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_status", 128'(dut_status()), 128'(st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h6C)));
            chk("hold_ct", io.ct_out, want_ct);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        chk("post_handshake", 128'(dut_status()), 128'(st(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01)));
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] want_ct, input int hold);
        start_block(pt, key);
        run_rounds(pt, key, want_ct, hold);
    endtask

    // Bounded run time regardless of DUT behaviour
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence
    initial begin
        logic [127:0] pt, key;
        rst = 1'b1;
        io.in_valid = 1'b0;  io.out_ready = 1'b0;  io.pt_in = '0;  io.key_in = '0;
        io1.in_valid = 1'b0; io1.out_ready = 1'b0; io1.pt_in = '0; io1.key_in = '0;
        #12;
        chk("reset_status", 128'(dut_status()), 128'(st(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01)));
        chk("reset_ct", io.ct_out, 128'd0);
        chk("reset_ks_key", ks_key, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_status", 128'(dut_status()), 128'(st(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01)));

        // FIPS-197 C.1 and App. B (the latter with 20 cycles of backpressure)
        run_block(C1_PT, C1_KEY, C1_CT, 0);
        run_block(B_PT, B_KEY, B_CT, 20);
        run_block(C1_PT, C1_KEY, C1_CT, 0);

        // Reset asserted during round 5
        start_block(B_PT, B_KEY);
        repeat (4) @(negedge clk);
        chk("round5_status", 128'(dut_status()),
            128'(st(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, RCON_TAB[4])));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_status", 128'(dut_status()),
            128'(st(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01)));
        chk("async_rst_ct", io.ct_out, 128'd0);
        chk("async_rst_ks_key", ks_key, 128'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("no_out_valid_after_rst", 128'(io.out_valid), 128'(1'b0));
        end
        run_block(C1_PT, C1_KEY, C1_CT, 1);

`ifdef AES128_ROUND_CTRL_ABORT_EN
        // Abort in round 3
        start_block(B_PT, B_KEY);
        repeat (2) @(negedge clk);
        chk("round3_status", 128'(round_cnt), 128'(4'd3));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_status", 128'(dut_status()), 128'(st(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01)));
        chk("abort_ct", io.ct_out, 128'd0);
        chk("abort_ks_key", ks_key, 128'd0);
        repeat (12) begin
            @(negedge clk);
            chk("no_out_valid_after_abort", 128'(io.out_valid), 128'(1'b0));
        end
        run_block(C1_PT, C1_KEY, C1_CT, 0);
`endif

        // Randomized blocks against the reference model
        for (int k = 0; k < 12; k++) begin
            pt  = rand128();
            key = rand128();
            run_block(pt, key, ref_encrypt(pt, key, NR), int'($urandom_range(0, 4)));
        end

        // Reduced-round instance: NR=1 with the C.1 block
        chk("nr1_in_ready", 128'(io1.in_ready), 128'(1'b1));
        io1.in_valid = 1'b1; io1.pt_in = C1_PT; io1.key_in = C1_KEY;
        @(negedge clk);
        io1.in_valid = 1'b0; io1.pt_in = rand128(); io1.key_in = rand128();
        chk("nr1_round_status",
            128'({io1.in_ready, io1.out_valid, busy1, dp_final1, round_cnt1, ks_rcon1}),
            128'(st(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 8'h01)));
        @(negedge clk);
        chk("nr1_done_status",
            128'({io1.in_ready, io1.out_valid, busy1, dp_final1, round_cnt1, ks_rcon1}),
            128'(st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h02)));
        chk("nr1_ct", io1.ct_out, ref_encrypt(C1_PT, C1_KEY, 1));
        io1.out_ready = 1'b1;
        @(negedge clk);
        io1.out_ready = 1'b0;
        chk("nr1_idle",
            128'({io1.in_ready, io1.out_valid, busy1, dp_final1, round_cnt1, ks_rcon1}),
            128'(st(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
